// File: rtl/rv_mem_pkg.sv
// Shared RV32I memory-access constants: funct3 encodings, NOP and the
// LOAD/STORE opcodes used by both the control unit and the datapath.
package rv_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  function automatic logic f3_is_load(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/mem_fetch_unit_load_align.sv
// Load-data formatter: picks the addressed byte/half out of the MDR and
// sign- or zero-extends it according to funct3.
module load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] mdr,
  input  logic [1:0]  alo,
  input  logic [2:0]  f3,
  output logic [31:0] load_data
);

  logic [31:0] mdr_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    mdr_shift = mdr >> {alo, 3'b000};
    byte_sel  = mdr_shift[7:0];
    half_sel  = alo[1] ? mdr[31:16] : mdr[15:0];
    case (f3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {24'h0, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {16'h0, half_sel};
      default: load_data = mdr;
    endcase
  end

endmodule

// File: rtl/mem_fetch_unit.sv
// Multi-cycle RV32I datapath front end: PC/OldPC/IR/MDR registers, unified
// memory port with lane-formatted stores and misaligned-access trapping.
module mem_fetch_unit
  import rv_mem_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        ir_write,
  input  logic        adr_src,
  input  logic        mem_write,
  input  logic [31:0] result,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  output logic [31:0] instr,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic [31:0] fault_addr,
  output logic [31:0] instr_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] old_pc_q, old_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] mdr_q;
  logic [1:0]  alo_q;
  logic        misaligned_q, misaligned_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] instr_count_q, instr_count_d;

  logic [31:0] eff;
  logic [2:0]  f3;
  logic        is_half, is_word, check_en, mis_now;
  logic [3:0]  be_raw;

  assign eff = adr_src ? result : pc_q;
  assign f3  = instr_q[14:12];

  always_comb begin
    is_half  = (f3[1:0] == 2'b01);
    is_word  = (f3[1:0] == 2'b10);
    check_en = adr_src & (mem_write | f3_is_load(f3));
    mis_now  = check_en & ((is_half & eff[0]) | (is_word & (eff[1:0] != 2'b00)));
    case (f3)
      F3_SB:   be_raw = 4'b0001 << eff[1:0];
      F3_SH:   be_raw = 4'b0011 << eff[1:0];
      F3_SW:   be_raw = 4'b1111;
      default: be_raw = 4'b0000;
    endcase
  end

  // Reset gates the strobe directly so an in-flight store dies in the same cycle.
  assign mem_we    = mem_write & ~mis_now & ~reset;
  assign mem_be    = mem_we ? be_raw : 4'b0000;
  assign mem_addr  = {eff[31:2], 2'b00};
  assign mem_wdata = store_data << {eff[1:0], 3'b000};

  always_comb begin
    pc_d          = pc_write ? {result[31:1], 1'b0} : pc_q;
    old_pc_d      = ir_write ? pc_q : old_pc_q;
    instr_d       = ir_write ? mem_rdata : instr_q;
    instr_count_d = ir_write ? instr_count_q + 32'd1 : instr_count_q;
    misaligned_d  = misaligned_q | mis_now;
    fault_addr_d  = (mis_now & ~misaligned_q) ? eff : fault_addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      old_pc_q      <= RESET_PC;
      instr_q       <= NOP_INSTR;
      mdr_q         <= 32'h0;
      alo_q         <= 2'b00;
      misaligned_q  <= 1'b0;
      fault_addr_q  <= 32'h0;
      instr_count_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      old_pc_q      <= old_pc_d;
      instr_q       <= instr_d;
      mdr_q         <= mem_rdata;
      alo_q         <= eff[1:0];
      misaligned_q  <= misaligned_d;
      fault_addr_q  <= fault_addr_d;
      instr_count_q <= instr_count_d;
    end
  end

  load_align u_load_align (
    .mdr       (mdr_q),
    .alo       (alo_q),
    .f3        (f3),
    .load_data (load_data)
  );

  assign pc          = pc_q;
  assign old_pc      = old_pc_q;
  assign instr       = instr_q;
  assign misaligned  = misaligned_q;
  assign fault_addr  = fault_addr_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Directed bench for mem_fetch_unit: fetch, stores, loads, misalignment,
// PC bit-0 clearing, instruction-count wrap and reset abort.
module tb_mem_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, pc_write, ir_write, adr_src, mem_write;
  logic [31:0] result, store_data, mem_rdata;
  logic [31:0] mem_addr, mem_wdata, pc, old_pc, instr, load_data, fault_addr, instr_count;
  logic [3:0]  mem_be;
  logic        mem_we, misaligned;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .ir_write(ir_write),
    .adr_src(adr_src), .mem_write(mem_write), .result(result),
    .store_data(store_data), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we), .pc(pc),
    .old_pc(old_pc), .instr(instr), .load_data(load_data),
    .misaligned(misaligned), .fault_addr(fault_addr), .instr_count(instr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] w);
    mem_rdata = w;
    ir_write  = 1'b1;
    tick();
    ir_write  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pc_write = 0; ir_write = 0; adr_src = 0; mem_write = 0;
    result = 0; store_data = 0; mem_rdata = 0;
    tick(); tick();
    n_total++; if (mem_addr !== 32'h100) $display("FAIL rst_mem_addr actual=%h required=%h", mem_addr, 32'h100); else n_pass++;
    n_total++; if (load_data !== 32'h0) $display("FAIL rst_load_data actual=%h required=%h", load_data, 32'h0); else n_pass++;
    @(negedge clk); reset = 1'b0;
    tick();
    n_total++; if (pc !== 32'h100) $display("FAIL rst_pc actual=%h required=%h", pc, 32'h100); else n_pass++;
    n_total++; if (old_pc !== 32'h100) $display("FAIL rst_old_pc actual=%h required=%h", old_pc, 32'h100); else n_pass++;
    n_total++; if (instr !== 32'h13) $display("FAIL rst_instr actual=%h required=%h", instr, 32'h13); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we actual=%b required=0", mem_we); else n_pass++;
    n_total++; if (instr_count !== 32'h0) $display("FAIL rst_instr_count actual=%h required=0", instr_count); else n_pass++;
    n_total++; if ({misaligned, fault_addr} !== 33'h0) $display("FAIL rst_fault actual=%b/%h required=0/0", misaligned, fault_addr); else n_pass++;
  endtask

  task automatic test_fetch();
    pc_write = 1; ir_write = 1; adr_src = 0; mem_rdata = 32'h0050_0093; result = 32'h104;
    #1;
    n_total++; if (mem_addr !== 32'h100) $display("FAIL fetch_addr actual=%h required=%h", mem_addr, 32'h100); else n_pass++;
    tick();
    pc_write = 0; ir_write = 0;
    n_total++; if (instr !== 32'h0050_0093) $display("FAIL fetch_instr actual=%h required=%h", instr, 32'h0050_0093); else n_pass++;
    n_total++; if (old_pc !== 32'h100) $display("FAIL fetch_old_pc actual=%h required=%h", old_pc, 32'h100); else n_pass++;
    n_total++; if (pc !== 32'h104) $display("FAIL fetch_pc actual=%h required=%h", pc, 32'h104); else n_pass++;
    n_total++; if (instr_count !== 32'h1) $display("FAIL fetch_count actual=%h required=1", instr_count); else n_pass++;
  endtask

  task automatic test_pc_bit0();
    pc_write = 1; result = 32'h0000_0111;
    tick();
    pc_write = 0;
    n_total++; if (pc !== 32'h0000_0110) $display("FAIL pc_bit0 actual=%h required=%h", pc, 32'h110); else n_pass++;
  endtask

  task automatic test_store_byte();
    set_instr(32'h0000_0023);
    adr_src = 1; result = 32'h203; store_data = 32'h0000_00AB; mem_write = 1;
    #1;
    n_total++; if (mem_addr !== 32'h200) $display("FAIL sb_addr actual=%h required=%h", mem_addr, 32'h200); else n_pass++;
    n_total++; if (mem_be !== 4'b1000) $display("FAIL sb_be actual=%b required=1000", mem_be); else n_pass++;
    n_total++; if (mem_wdata !== 32'hAB00_0000) $display("FAIL sb_wdata actual=%h required=%h", mem_wdata, 32'hAB00_0000); else n_pass++;
    n_total++; if (mem_we !== 1'b1) $display("FAIL sb_we actual=%b required=1", mem_we); else n_pass++;
    result = 32'h201; store_data = 32'h0000_BEEF;
    set_instr(32'h0000_1023);
    mem_write = 1; adr_src = 1; result = 32'h202;
    #1;
    n_total++; if ({mem_be, mem_wdata} !== {4'b1100, 32'hBEEF_0000}) $display("FAIL sh_lane actual=%b/%h required=1100/beef0000", mem_be, mem_wdata); else n_pass++;
    tick();
    mem_write = 0; adr_src = 0;
  endtask

  task automatic test_loads();
    logic [31:0] ins [4]  = '{32'h0000_0003, 32'h0000_4003, 32'h0000_1003, 32'h0000_5003};
    logic [31:0] adr [4]  = '{32'h202, 32'h202, 32'h202, 32'h200};
    logic [31:0] exp [4]  = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01};
    for (int i = 0; i < 4; i++) begin
      set_instr(ins[i]);
      adr_src = 1; result = adr[i]; mem_rdata = 32'h80FF_7F01;
      tick();
      adr_src = 0; mem_rdata = 32'h0;
      n_total++; if (load_data !== exp[i]) $display("FAIL load_%0d actual=%h required=%h", i, load_data, exp[i]); else n_pass++;
    end
    n_total++; if (misaligned !== 1'b0) $display("FAIL load_no_mis actual=%b required=0", misaligned); else n_pass++;
  endtask

  task automatic test_misaligned();
    set_instr(32'h0000_2023);
    adr_src = 1; result = 32'h206; store_data = 32'h1234_5678; mem_write = 1;
    #1;
    n_total++; if ({mem_we, mem_be} !== 5'b0) $display("FAIL sw_mis_strobe actual=%b/%b required=0/0000", mem_we, mem_be); else n_pass++;
    tick();
    mem_write = 0; adr_src = 0;
    n_total++; if (misaligned !== 1'b1) $display("FAIL sw_mis_flag actual=%b required=1", misaligned); else n_pass++;
    n_total++; if (fault_addr !== 32'h206) $display("FAIL sw_fault_addr actual=%h required=%h", fault_addr, 32'h206); else n_pass++;
    set_instr(32'h0000_1003);
    adr_src = 1; result = 32'h301;
    tick();
    adr_src = 0;
    n_total++; if (fault_addr !== 32'h206) $display("FAIL lh_fault_keep actual=%h required=%h", fault_addr, 32'h206); else n_pass++;
    n_total++; if (misaligned !== 1'b1) $display("FAIL mis_sticky actual=%b required=1", misaligned); else n_pass++;
  endtask

  task automatic test_count_wrap();
    force dut.instr_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_q;
    #1;
    n_total++; if (instr_count !== 32'hFFFF_FFFF) $display("FAIL count_preload actual=%h required=ffffffff", instr_count); else n_pass++;
    set_instr(32'h0000_0013);
    n_total++; if (instr_count !== 32'h0) $display("FAIL count_wrap actual=%h required=0", instr_count); else n_pass++;
  endtask

  task automatic test_reset_mid_store();
    set_instr(32'h0000_2023);
    adr_src = 1; result = 32'h400; mem_write = 1;
    #1;
    n_total++; if ({mem_we, mem_be} !== 5'b1_1111) $display("FAIL sw_ok actual=%b/%b required=1/1111", mem_we, mem_be); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++; if ({mem_we, mem_be} !== 5'b0) $display("FAIL rst_abort actual=%b/%b required=0/0000", mem_we, mem_be); else n_pass++;
    n_total++; if ({instr, misaligned} !== {32'h13, 1'b0}) $display("FAIL rst_abort_state actual=%h/%b required=00000013/0", instr, misaligned); else n_pass++;
    mem_write = 0; adr_src = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_pc_bit0();
    test_store_byte();
    test_loads();
    test_misaligned();
    test_count_wrap();
    test_reset_mid_store();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
